// File: rtl/height_frame_buffer_pkg.sv
// Shared constants and FSM encoding for the ping-pong column-height store.
package height_frame_buffer_pkg;
  localparam int SCREEN_WIDTH  = 640;
  localparam int SCREEN_HEIGHT = 480;
  localparam int HEIGHT_W      = 9;
  localparam int ADDR_W        = 10;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_FILL = 2'b01;
  localparam logic [1:0] ST_FULL = 2'b10;
endpackage

// File: rtl/height_frame_buffer_if.sv
// Writer handshake and renderer read port of the column-height store.
interface height_frame_buffer_if;
  import height_frame_buffer_pkg::*;

  // Write transfer happens on a clock edge where wr_valid && wr_ready; wr_valid
  // may be raised without waiting for wr_ready, and the writer holds its data until accepted.
  logic                wr_valid;
  logic                wr_ready;
  logic [ADDR_W-1:0]   wr_index;
  logic [HEIGHT_W-1:0] wr_height;
  logic                rd_en;
  logic [ADDR_W-1:0]   rd_addr;
  logic [HEIGHT_W-1:0] rd_data;

  modport master (
    output wr_valid, wr_index, wr_height, rd_en, rd_addr,
    input  wr_ready, rd_data
  );

  modport slave (
    input  wr_valid, wr_index, wr_height, rd_en, rd_addr,
    output wr_ready, rd_data
  );
endinterface

// File: rtl/height_frame_buffer_column_bank_ram.sv
// One column bank: single write port and synchronous read port (BRAM style).
module column_bank_ram #(
  parameter int DEPTH = 640,
  parameter int DW    = 9,
  parameter int AW    = 10
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata_q <= mem[raddr];
  end

  assign rdata = rdata_q;
endmodule

// File: rtl/height_frame_buffer.sv
// Ping-pong column-height store: writer fills the back bank, renderer reads the
// front bank, and the banks swap only at a frame boundary.
module height_frame_buffer
  import height_frame_buffer_pkg::*;
#(
  parameter int WIDTH = SCREEN_WIDTH
) (
  input  logic                 clk,
  input  logic                 reset_n,
  height_frame_buffer_if.slave bus,
  input  logic                 frame_end,
  output logic                 new_frame_req,
  output logic                 data_initialised,
  output logic                 buf_sel,
  output logic                 seq_error,
  output logic [1:0]           fsm_state
);
  localparam logic [ADDR_W:0]   WIDTH_A  = (ADDR_W+1)'(WIDTH);
  localparam logic [ADDR_W-1:0] LAST_COL = ADDR_W'(WIDTH - 1);

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic              buf_sel_q, buf_sel_d;
  logic              init_q, init_d;
  logic              err_q, err_d;
  logic              nfr_q, nfr_d;
  logic              rd_ok_q, rd_ok_d;
  logic              rd_bank_q, rd_bank_d;

  logic                xfer, wr_en, rd_in_range;
  logic                we0, we1, re0, re1;
  logic [HEIGHT_W-1:0] dout0, dout1;

  assign xfer        = bus.wr_valid && bus.wr_ready;
  assign rd_in_range = {1'b0, bus.rd_addr} < WIDTH_A;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    buf_sel_d = buf_sel_q;
    init_d    = init_q;
    err_d     = err_q;
    nfr_d     = 1'b0;
    wr_en     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        nfr_d   = 1'b1;
        state_d = ST_FILL;
      end
      ST_FILL: begin
        if (xfer) begin
          if (bus.wr_index == idx_q && {1'b0, bus.wr_index} < WIDTH_A) begin
            wr_en = 1'b1;
            if (idx_q == LAST_COL) begin
              idx_d   = '0;
              state_d = ST_FULL;
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_FULL: begin
        // The very first frame is shown at once; later ones wait for the boundary.
        if (!init_q || frame_end) begin
          buf_sel_d = ~buf_sel_q;
          init_d    = 1'b1;
          nfr_d     = 1'b1;
          state_d   = ST_FILL;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    rd_ok_d   = rd_ok_q;
    rd_bank_d = rd_bank_q;
    if (bus.rd_en) begin
      rd_ok_d   = rd_in_range && init_q;
      rd_bank_d = buf_sel_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      buf_sel_q <= 1'b0;
      init_q    <= 1'b0;
      err_q     <= 1'b0;
      nfr_q     <= 1'b0;
      rd_ok_q   <= 1'b0;
      rd_bank_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      buf_sel_q <= buf_sel_d;
      init_q    <= init_d;
      err_q     <= err_d;
      nfr_q     <= nfr_d;
      rd_ok_q   <= rd_ok_d;
      rd_bank_q <= rd_bank_d;
    end
  end

  // Writes go to the back bank (~buf_sel), reads to the front bank only.
  assign we0 = wr_en && buf_sel_q;
  assign we1 = wr_en && !buf_sel_q;
  assign re0 = bus.rd_en && rd_in_range && !buf_sel_q;
  assign re1 = bus.rd_en && rd_in_range && buf_sel_q;

  column_bank_ram #(.DEPTH(WIDTH), .DW(HEIGHT_W), .AW(ADDR_W)) u_bank0 (
    .clk   (clk),
    .we    (we0),
    .waddr (bus.wr_index),
    .wdata (bus.wr_height),
    .re    (re0),
    .raddr (bus.rd_addr),
    .rdata (dout0)
  );

  column_bank_ram #(.DEPTH(WIDTH), .DW(HEIGHT_W), .AW(ADDR_W)) u_bank1 (
    .clk   (clk),
    .we    (we1),
    .waddr (bus.wr_index),
    .wdata (bus.wr_height),
    .re    (re1),
    .raddr (bus.rd_addr),
    .rdata (dout1)
  );

  assign bus.wr_ready     = (state_q == ST_FILL);
  assign bus.rd_data      = rd_ok_q ? (rd_bank_q ? dout1 : dout0) : '0;
  assign new_frame_req    = nfr_q;
  assign data_initialised = init_q;
  assign buf_sel          = buf_sel_q;
  assign seq_error        = err_q;
  assign fsm_state        = state_q;
endmodule

// File: tb/tb_height_frame_buffer.sv
// Bench for height_frame_buffer: directed frame scenarios plus randomized
// traffic, checked every cycle against a frame-level reference model.
module tb_height_frame_buffer;
  import height_frame_buffer_pkg::*;

  localparam int W = SCREEN_WIDTH;

  logic       clk;
  logic       reset_n;
  logic       frame_end;
  logic       new_frame_req;
  logic       data_initialised;
  logic       buf_sel;
  logic       seq_error;
  logic [1:0] fsm_state;

  height_frame_buffer_if bus ();

  height_frame_buffer dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .bus              (bus),
    .frame_end        (frame_end),
    .new_frame_req    (new_frame_req),
    .data_initialised (data_initialised),
    .buf_sel          (buf_sel),
    .seq_error        (seq_error),
    .fsm_state        (fsm_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  // A frame being assembled (pending) and the frame on screen (displayed).
  int  displayed [W];
  int  pending   [W];
  bit  starting;
  bit  accepting;
  bit  shown;
  bit  m_front;
  bit  m_err;
  bit  m_nfr;
  bit  last_acc;
  int  next_col;
  logic [HEIGHT_W-1:0] m_rd;
  logic [HEIGHT_W-1:0] exp_q [$];

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    starting  = 1'b1;
    accepting = 1'b0;
    shown     = 1'b0;
    m_front   = 1'b0;
    m_err     = 1'b0;
    m_nfr     = 1'b0;
    last_acc  = 1'b0;
    next_col  = 0;
    m_rd      = '0;
    exp_q.delete();
  endtask

  // Applies the inputs present at a rising edge to the model.
  task automatic model_update();
    int a;
    if (!reset_n) begin
      model_reset();
      return;
    end
    if (bus.rd_en) begin
      a = int'(bus.rd_addr);
      exp_q.push_back((shown && a < W) ? HEIGHT_W'(displayed[a]) : '0);
    end
    m_nfr    = 1'b0;
    last_acc = 1'b0;
    if (starting) begin
      starting  = 1'b0;
      accepting = 1'b1;
      m_nfr     = 1'b1;
    end else if (accepting) begin
      if (bus.wr_valid) begin
        if (int'(bus.wr_index) == next_col && next_col < W) begin
          pending[next_col] = int'(bus.wr_height);
          last_acc = 1'b1;
          next_col++;
          if (next_col == W) begin
            next_col  = 0;
            accepting = 1'b0;
          end
        end else begin
          m_err = 1'b1;
        end
      end
    end else if (!shown || frame_end) begin
      displayed = pending;
      shown     = 1'b1;
      m_front   = ~m_front;
      m_nfr     = 1'b1;
      accepting = 1'b1;
    end
  endtask

  task automatic check_outputs();
    if (exp_q.size() > 0) m_rd = exp_q.pop_front();
    check_eq("wr_ready", bus.wr_ready, accepting);
    check_eq("new_frame_req", new_frame_req, m_nfr);
    check_eq("data_initialised", data_initialised, shown);
    check_eq("buf_sel", buf_sel, m_front);
    check_eq("seq_error", seq_error, m_err);
    check_eq("rd_data", bus.rd_data, m_rd);
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    @(negedge clk);
    check_outputs();
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    bus.wr_valid  = 1'b0;
    bus.wr_index  = '0;
    bus.wr_height = '0;
    bus.rd_en     = 1'b0;
    bus.rd_addr   = '0;
    frame_end     = 1'b0;
  endtask

  function automatic logic [HEIGHT_W-1:0] hgt(input int mode, input int col);
    case (mode)
      0:       return HEIGHT_W'(col);
      1:       return HEIGHT_W'(200);
      default: return HEIGHT_W'($urandom_range(0, 511));
    endcase
  endfunction

  task automatic read_col(input int addr);
    idle_inputs();
    bus.rd_en   = 1'b1;
    bus.rd_addr = ADDR_W'(addr);
    tick();
    idle_inputs();
  endtask

  task automatic pulse_frame_end();
    idle_inputs();
    frame_end = 1'b1;
    tick();
    idle_inputs();
  endtask

  task automatic present(input int idx, input bit fe);
    idle_inputs();
    bus.wr_valid  = 1'b1;
    bus.wr_index  = ADDR_W'(idx);
    bus.wr_height = hgt(2, idx);
    frame_end     = fe;
    tick();
    idle_inputs();
  endtask

  task automatic write_range(input int first, input int last, input int mode,
                             input int fe_col, input bit rnd);
    for (int col = first; col <= last; col++) begin
      int budget = 0;
      logic [HEIGHT_W-1:0] h = hgt(mode, col);
      bit done = 1'b0;
      while (!done) begin
        bus.wr_valid  = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
        bus.wr_index  = ADDR_W'(col);
        bus.wr_height = h;
        frame_end     = (col == fe_col) || (rnd && $urandom_range(0, 49) == 0);
        bus.rd_en     = 1'($urandom_range(0, 1));
        bus.rd_addr   = ADDR_W'($urandom_range(0, 700));
        tick();
        done = last_acc;
        budget++;
        if (!done && budget >= 2000) begin
          n_checks++;
          n_errors++;
          $display("FAIL write_budget: column %0d not accepted after %0d cycles", col, budget);
          idle_inputs();
          return;
        end
      end
    end
    idle_inputs();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    reset_n = 1'b0;
    idle_inputs();
    model_reset();
    repeat (3) tick();
    check_eq("rst_wr_ready", bus.wr_ready, 0);
    check_eq("rst_nfr", new_frame_req, 0);
    check_eq("rst_rd_data", bus.rd_data, 0);
    check_eq("rst_init", data_initialised, 0);
    check_eq("rst_buf_sel", buf_sel, 0);
    check_eq("rst_seq_error", seq_error, 0);
    reset_n = 1'b1;

    // Frame 1: heights equal column index; shown without a frame_end.
    write_range(0, W - 1, 0, -1, 1'b0);
    check_eq("f1_init_early", data_initialised, 0);
    tick();
    check_eq("f1_init", data_initialised, 1);
    check_eq("f1_buf_sel", buf_sel, 1);
    check_eq("f1_nfr", new_frame_req, 1);
    read_col(100);
    check_eq("f1_rd100", bus.rd_data, 100);

    // Frame 2: constant 200 with a frame_end mid-fill that must not swap.
    write_range(0, W - 1, 1, 300, 1'b0);
    read_col(5);
    check_eq("f2_old_rd5", bus.rd_data, 5);
    repeat (3) tick();
    check_eq("f2_no_swap", buf_sel, 1);
    pulse_frame_end();
    check_eq("f2_buf_sel", buf_sel, 0);
    check_eq("f2_nfr", new_frame_req, 1);
    read_col(5);
    check_eq("f2_rd5", bus.rd_data, 200);

    // Frame 3: out-of-order write, then frame_end with the final column.
    write_range(0, 4, 2, -1, 1'b0);
    present(7, 1'b0);
    check_eq("f3_seq_error", seq_error, 1);
    write_range(5, W - 1, 2, W - 1, 1'b0);
    repeat (3) tick();
    check_eq("f3_no_swap", buf_sel, 0);
    pulse_frame_end();
    check_eq("f3_swap", buf_sel, 1);
    read_col(640);
    check_eq("f3_rd640", bus.rd_data, 0);
    read_col(5);
    read_col(639);

    // Frame 4: asynchronous reset in the middle of a fill.
    write_range(0, 319, 2, -1, 1'b0);
    #2 reset_n = 1'b0;
    #1;
    check_eq("arst_wr_ready", bus.wr_ready, 0);
    check_eq("arst_nfr", new_frame_req, 0);
    check_eq("arst_rd_data", bus.rd_data, 0);
    check_eq("arst_init", data_initialised, 0);
    check_eq("arst_buf_sel", buf_sel, 0);
    check_eq("arst_seq_error", seq_error, 0);
    model_reset();
    repeat (2) tick();
    reset_n = 1'b1;
    tick();
    check_eq("arst_nfr_again", new_frame_req, 1);
    present(640, 1'b0);
    check_eq("oor_seq_error", seq_error, 1);

    // Randomized frames with gaps, stray frame_end pulses and reads.
    repeat (3) write_range(0, W - 1, 2, -1, 1'b1);
    repeat (300) begin
      bus.rd_en   = 1'($urandom_range(0, 1));
      bus.rd_addr = ADDR_W'($urandom_range(0, 700));
      frame_end   = ($urandom_range(0, 29) == 0);
      tick();
    end
    idle_inputs();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
